inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Issuing side of the cpu controller's run/done handshake.
//  Fetches 16-bit instructions from a synchronous-read instruction memory and presents each on d_inst.
//  Pulses run for one cycle, then waits for done before advancing the PC.
//  Also detects the halt opcode, end of program, and a hung controller (watchdog timeout).
// PARAMETERS
//  ADDR_W   8        instruction memory address width
//  PROG_LEN 256      number of valid program words (1..2**ADDR_W)
//  HALT_OP  16'hFFFF opcode that stops sequencing; it is never issued
//  TIMEOUT  15       max EXEC cycles without done before error (>=4)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       level; sampled in IDLE/HALTED/ERROR, begins program at addr 0
//  imem_rd    out  1       memory read strobe; data returned one cycle later
//  imem_addr  out  ADDR_W  read address (= pc)
//  imem_data  in   16      read data, valid the cycle after imem_rd
//  d_inst     out  16      instruction to controller; stable from ISSUE until the next latch
//  run        out  1       one-cycle issue pulse to controller
//  done       in   1       controller completion pulse
//  busy       out  1       high in FETCH/WAIT_MEM/ISSUE/EXEC
//  halted     out  1       high in HALTED
//  err        out  1       high in ERROR (watchdog fired)
//  inst_count out  16      instructions completed since last start; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; pc=0; d_inst=0; wdog=0; inst_count=0.
//   All outputs are 0 during reset.
//  FSM states: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALTED, ERROR.
//  IDLE:     start=1 -> FETCH; pc=0; inst_count=0.
//  FETCH:    imem_rd=1, imem_addr=pc -> WAIT_MEM.
//  WAIT_MEM: sample imem_data.
//   - imem_data==HALT_OP -> HALTED; d_inst is not updated.
//   - otherwise d_inst<=imem_data -> ISSUE.
//  ISSUE:    run=1 for exactly 1 cycle; wdog=0 -> EXEC.
//  EXEC:     run=0; wdog increments each cycle. On done=1:
//   - inst_count+1 (saturating).
//   - if pc==PROG_LEN-1 -> HALTED; else pc+1 -> FETCH.
//   - wdog reaching TIMEOUT with done=0 -> ERROR.
//   - done and timeout in the same cycle: done wins.
//  HALTED/ERROR: start=1 -> FETCH; pc=0; inst_count=0; flag clears on leaving.
//  Latency: start edge -> run high 3 cycles later (FETCH, WAIT_MEM, ISSUE).
//   done edge -> next run high 3 cycles later.
//  Edge cases:
//   - start while busy: ignored.
//   - done outside EXEC (incl. same cycle as run): ignored, not counted.
//   - pc never wraps; the end of program halts.
//   - reset_n mid-EXEC: immediate return to IDLE; run, d_inst and flags clear asynchronously.
//  Width rules:
//   - pc is ADDR_W bits.
//   - wdog is $clog2(TIMEOUT+1) bits.
//   - imem_addr equals pc in every state.
// TESTING
//  1 Reset: reset_n=0 mid-EXEC -> run=0, d_inst=0, busy=0 same cycle; IDLE after release.
//  2 Basic: mem[0]=16'h2405, mem[1]=HALT_OP; start pulse, done 2 cycles after run
//    -> one run pulse with d_inst=16'h2405; halted=1; inst_count=1.
//  3 End of program: PROG_LEN=3, no halt words, done always returned
//    -> 3 run pulses, addrs 0,1,2; halted=1; inst_count=3.
//  4 Watchdog: TIMEOUT=15, withhold done -> err=1 on the 15th EXEC cycle.
//    start -> err clears, fetch from addr 0.
//  5 Race: done asserted on the exact timeout cycle -> no err; pc advances.
//  6 Noise: start pulses while busy, and done pulses in FETCH/ISSUE
//    -> no restart, inst_count unchanged, run count matches program.

Source files
------------

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer
// Description : Issuing side of the run/done handshake. Fetches instructions,
//               issues them one at a time, and stops on halt, end of program
//               or a hung controller.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sequencer #(
    parameter int          ADDR_W   = 8,
    parameter int          PROG_LEN = 256,
    parameter logic [15:0] HALT_OP  = 16'hFFFF,
    parameter int          TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       d_inst,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       inst_count
);

    localparam int                  c_WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0]   c_LAST_PC   = ADDR_W'(PROG_LEN - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LIM  = c_WDOG_W'(TIMEOUT);
    localparam logic [15:0]         c_COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_ISSUE    = 3'd3,
        S_EXEC     = 3'd4,
        S_HALTED   = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_d_inst;
    logic [c_WDOG_W-1:0] r_wdog;
    logic [c_WDOG_W-1:0] w_wdog_inc;
    logic [15:0]         r_inst_count;
    logic                w_restart;
    logic                w_accept;
    logic                w_latch;

    assign w_wdog_inc = r_wdog + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Done takes priority over the watchdog when both land in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_accept     = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (imem_data == HALT_OP) begin
                    w_state_next = S_HALTED;
                end else begin
                    w_latch      = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (done) begin
                    w_accept     = 1'b1;
                    w_state_next = (r_pc == c_LAST_PC) ? S_HALTED : S_FETCH;
                end else if (w_wdog_inc == c_WDOG_LIM) begin
                    w_state_next = S_ERROR;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else if (w_restart) begin
            r_pc <= '0;
        end else if (w_accept && (r_pc != c_LAST_PC)) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_inst <= 16'h0000;
        end else if (w_latch) begin
            r_d_inst <= imem_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdog <= '0;
        end else if (r_state == S_EXEC) begin
            r_wdog <= w_wdog_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inst_count <= 16'h0000;
        end else if (w_restart) begin
            r_inst_count <= 16'h0000;
        end else if (w_accept && (r_inst_count != c_COUNT_MAX)) begin
            r_inst_count <= r_inst_count + 16'd1;
        end
    end

    assign imem_rd    = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign d_inst     = r_d_inst;
    assign run        = (r_state == S_ISSUE);
    assign busy       = (r_state == S_FETCH) || (r_state == S_WAIT_MEM) ||
                        (r_state == S_ISSUE) || (r_state == S_EXEC);
    assign halted     = (r_state == S_HALTED);
    assign err        = (r_state == S_ERROR);
    assign inst_count = r_inst_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sequencer
// Description : Self-checking bench for inst_sequencer with a program-level
//               reference model and randomized done timing and noise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sequencer;

    localparam int          ADDR_W   = 4;
    localparam int          PROG_LEN = 3;
    localparam logic [15:0] HALT_OP  = 16'hFFFF;
    localparam int          TIMEOUT  = 15;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              start     = 1'b0;
    logic              done      = 1'b0;
    logic [15:0]       imem_data = 16'h0000;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       d_inst;
    logic              run;
    logic              busy;
    logic              halted;
    logic              err;
    logic [15:0]       inst_count;

    inst_sequencer #(
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN),
        .HALT_OP  (HALT_OP),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .d_inst     (d_inst),
        .run        (run),
        .done       (done),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2**ADDR_W];

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    int                run_cnt = 0;
    logic [ADDR_W-1:0] fetch_q [$];

    always @(negedge clk) begin
        if (run === 1'b1) run_cnt++;
        if (imem_rd === 1'b1) fetch_q.push_back(imem_addr);
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_inst [$];
    int          exp_fetch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the program as the controller sees it: stop at halt or after the last word.
    task automatic build_model();
        exp_inst.delete();
        exp_fetch = 0;
        for (int k = 0; k < PROG_LEN; k++) begin
            exp_fetch++;
            if (mem[k] == HALT_OP) break;
            exp_inst.push_back(mem[k]);
        end
    endtask

    task automatic run_program(input string name, input bit noise, input int fixed_delay);
        int lat;
        int delay;
        build_model();
        run_cnt = 0;
        fetch_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < exp_inst.size(); i++) begin
            lat = 0;
            while (run !== 1'b1 && lat < 12) begin
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    done  = 1'($urandom_range(0, 1));
                end
                tick();
                lat++;
            end
            start = 1'b0;
            done  = 1'b0;
            check($sformatf("%s inst%0d latency", name, i), lat, 2);
            check($sformatf("%s inst%0d d_inst", name, i), d_inst, exp_inst[i]);
            check($sformatf("%s inst%0d busy", name, i), busy, 1'b1);
            if (noise) begin
                done  = 1'b1;
                start = 1'b1;
            end
            tick();
            done  = 1'b0;
            start = 1'b0;
            delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, TIMEOUT));
            for (int c = 1; c < delay; c++) begin
                if (noise) start = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            check($sformatf("%s inst%0d run in exec", name, i), run, 1'b0);
            check($sformatf("%s inst%0d err in exec", name, i), err, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        lat = 0;
        while (halted !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
        check($sformatf("%s halted", name), halted, 1'b1);
        check($sformatf("%s busy at end", name), busy, 1'b0);
        check($sformatf("%s err at end", name), err, 1'b0);
        check($sformatf("%s inst_count", name), inst_count, exp_inst.size());
        check($sformatf("%s run pulses", name), run_cnt, exp_inst.size());
        check($sformatf("%s fetch count", name), fetch_q.size(), exp_fetch);
        for (int k = 0; k < fetch_q.size(); k++) begin
            check($sformatf("%s fetch addr %0d", name, k), fetch_q[k], k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int k = 0; k < 2**ADDR_W; k++) mem[k] = 16'h0000;

        // Outputs while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset run", run, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset halted", halted, 1'b0);
        check("reset err", err, 1'b0);
        check("reset imem_rd", imem_rd, 1'b0);
        check("reset imem_addr", imem_addr, 0);
        check("reset d_inst", d_inst, 16'h0000);
        check("reset inst_count", inst_count, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check("idle without start busy", busy, 1'b0);

        // Halt opcode at address 1.
        mem[0] = 16'h2405;
        mem[1] = HALT_OP;
        mem[2] = 16'h1111;
        run_program("basic", 1'b0, 2);
        check("basic d_inst kept", d_inst, 16'h2405);

        // Run off the end of the program.
        mem[0] = 16'hA001;
        mem[1] = 16'hB002;
        mem[2] = 16'hC003;
        run_program("eop", 1'b0, 0);

        // Done exactly on the last watchdog cycle must win.
        mem[0] = 16'h0F0F;
        mem[1] = 16'h7777;
        mem[2] = 16'h1234;
        run_program("race", 1'b0, TIMEOUT);

        run_program("noise", 1'b1, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < PROG_LEN; k++) mem[k] = 16'($urandom_range(0, 16'hFFFE));
            if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, PROG_LEN - 1)] = HALT_OP;
            run_program($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0);
        end

        // Watchdog: withhold done.
        mem[0] = 16'h5A5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("wdog run", run, 1'b1);
        tick();
        for (int c = 1; c <= TIMEOUT; c++) begin
            check($sformatf("wdog exec cycle %0d err", c), err, 1'b0);
            tick();
        end
        check("wdog err", err, 1'b1);
        check("wdog busy", busy, 1'b0);
        check("wdog inst_count", inst_count, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wdog restart err", err, 1'b0);
        check("wdog restart imem_rd", imem_rd, 1'b1);
        check("wdog restart addr", imem_addr, 0);

        // Asynchronous reset in the middle of EXEC.
        tick();
        tick();
        tick();
        check("pre-reset d_inst", d_inst, 16'h5A5A);
        check("pre-reset busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset run", run, 1'b0);
        check("async reset d_inst", d_inst, 16'h0000);
        check("async reset busy", busy, 1'b0);
        check("async reset inst_count", inst_count, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check("post-reset busy", busy, 1'b0);
        check("post-reset halted", halted, 1'b0);
        check("post-reset err", err, 1'b0);
        check("post-reset imem_addr", imem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
